// File: rtl/ram_loader.sv
// Bus initiator for the 16x8 RAM: streams bytes in (load), streams RAM out (dump), or clears it.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running byte checksum output.
module ram_loader #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              dump_start,
    input  logic              clear_start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_reset,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DUMP_REQ,
        S_DUMP_WAIT,
        S_DUMP_OUT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic              accept_op;
    logic              load_hs;
    logic              dump_hs;

    assign accept_op   = (state == S_IDLE) && !clear_start && (load_start || dump_start);
    assign load_hs     = (state == S_LOAD) && in_valid;
    assign dump_hs     = (state == S_DUMP_OUT) && out_ready;
    assign ram_address = addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            addr     <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept_op) begin
                addr <= start_addr;
                cnt  <= length;
            end else if (load_hs || dump_hs) begin
                addr <= addr + 1'b1;
                cnt  <= cnt - 1'b1;
            end
            if (state == S_DUMP_WAIT) begin
                out_data <= ram_data_out;
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        ram_write_enable = 1'b0;
        ram_reset        = 1'b0;
        ram_data_in      = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (clear_start) begin
                    state_nxt = S_CLEAR;
                end else if (load_start) begin
                    state_nxt = (length == '0) ? S_DONE : S_LOAD;
                end else if (dump_start) begin
                    state_nxt = (length == '0) ? S_DONE : S_DUMP_REQ;
                end
            end
            S_LOAD: begin
                in_ready         = 1'b1;
                ram_data_in      = in_data;
                ram_write_enable = in_valid;
                if (in_valid && (cnt == (ADDR_W+1)'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DUMP_REQ:  state_nxt = S_DUMP_WAIT;
            S_DUMP_WAIT: state_nxt = S_DUMP_OUT;
            S_DUMP_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = (cnt == (ADDR_W+1)'(1)) ? S_DONE : S_DUMP_REQ;
                end
            end
            S_CLEAR: begin
                ram_reset = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Reset cycle: suppress every strobe so a reset mid-LOAD cannot write the RAM.
        if (!reset) begin
            in_ready         = 1'b0;
            out_valid        = 1'b0;
            busy             = 1'b0;
            done             = 1'b0;
            ram_write_enable = 1'b0;
            ram_reset        = 1'b0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            checksum <= '0;
        end else if (accept_op) begin
            checksum <= '0;
        end else if (load_hs) begin
            checksum <= checksum + in_data;
        end else if (dump_hs) begin
            checksum <= checksum + out_data;
        end
    end
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader with a behavioural 16x8 RAM attached.
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start, dump_start, clear_start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic       busy, done;
    logic [3:0] ram_address;
    logic [7:0] ram_data_in;
    logic       ram_write_enable, ram_reset;
    logic [7:0] ram_data_out;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .dump_start(dump_start), .clear_start(clear_start),
        .start_addr(start_addr), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done),
        .ram_address(ram_address), .ram_data_in(ram_data_in),
        .ram_write_enable(ram_write_enable), .ram_reset(ram_reset),
        .ram_data_out(ram_data_out)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always @(posedge clk) begin
        if (ram_reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
            ram_data_out <= 8'h00;
        end else begin
            if (ram_write_enable) begin
                mem[ram_address] <= ram_data_in;
                wr_cnt <= wr_cnt + 1;
            end
            ram_data_out <= mem[ram_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick;
            n++;
        end
        check(tag, out_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int wr_before;
        reset = 1'b0; load_start = 0; dump_start = 0; clear_start = 0;
        start_addr = '0; length = '0; in_valid = 0; in_data = '0; out_ready = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        tick; tick;
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_we", ram_write_enable, 0);
        check("rst_ram_reset", ram_reset, 0);
        check("rst_addr", ram_address, 0);
        check("rst_din", ram_data_in, 0);
        check("rst_out_data", out_data, 0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        reset = 1'b1;
        tick;

        // Test 1: 16-byte load from address 0
        start_addr = 4'd0; length = 5'd16; load_start = 1;
        tick;
        load_start = 0;
        in_valid = 1;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'h10 + 8'(i);
            #1;
            check("ld_in_ready", in_ready, 1);
            check("ld_we", ram_write_enable, 1);
            check("ld_addr", ram_address, 32'(i));
            check("ld_din", ram_data_in, 32'(8'h10 + 8'(i)));
            tick;
        end
        in_valid = 0;
        #1;
        check("ld_done", done, 1);
        check("ld_done_busy", busy, 1);
        check("ld_done_in_ready", in_ready, 0);
        tick;
        check("ld_idle_done", done, 0);
        check("ld_idle_busy", busy, 0);
        check("ld_wr_cnt", wr_cnt, 16);
        check("ld_mem0", mem[0], 8'h10);
        check("ld_mem5", mem[5], 8'h15);
        check("ld_mem15", mem[15], 8'h1F);

        // Test 2: wrapping dump with back-pressure on the 2nd byte
        start_addr = 4'd14; length = 5'd4; dump_start = 1;
        tick;
        dump_start = 0; out_ready = 1;
        check("dp_req_valid", out_valid, 0);
        wait_out("dp_b0_timeout", n);
        check("dp_b0_latency", n, 2);
        check("dp_b0", out_data, 8'h1E);
        tick;
        out_ready = 0;
        wait_out("dp_b1_timeout", n);
        check("dp_b1_latency", n, 2);
        check("dp_b1", out_data, 8'h1F);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("dp_stall_valid", out_valid, 1);
            check("dp_stall_data", out_data, 8'h1F);
        end
        out_ready = 1;
        tick;
        wait_out("dp_b2_timeout", n);
        check("dp_b2", out_data, 8'h10);
        tick;
        wait_out("dp_b3_timeout", n);
        check("dp_b3", out_data, 8'h11);
        tick;
        check("dp_done", done, 1);
        check("dp_done_valid", out_valid, 0);
        tick;
        check("dp_idle_busy", busy, 0);

        // Test 3: clear, then a full dump reads zeros
        clear_start = 1;
        tick;
        clear_start = 0;
        check("clr_ram_reset", ram_reset, 1);
        check("clr_busy", busy, 1);
        tick;
        check("clr_ram_reset_off", ram_reset, 0);
        check("clr_done", done, 1);
        tick;
        start_addr = 4'd0; length = 5'd16; dump_start = 1;
        tick;
        dump_start = 0;
        for (int i = 0; i < 16; i++) begin
            wait_out("clr_dp_timeout", n);
            check("clr_dp_data", out_data, 8'h00);
            tick;
        end
        check("clr_dp_done", done, 1);
        tick;

        // Test 4: priority, ignored dump while loading, zero-length load
        clear_start = 1; load_start = 1; start_addr = 4'd2; length = 5'd3;
        tick;
        clear_start = 0; load_start = 0;
        check("pri_ram_reset", ram_reset, 1);
        check("pri_in_ready", in_ready, 0);
        tick;
        check("pri_done", done, 1);
        tick;
        start_addr = 4'd3; length = 5'd2; load_start = 1;
        tick;
        load_start = 0; dump_start = 1; in_valid = 1; in_data = 8'h55;
        tick;
        dump_start = 0; in_data = 8'h66;
        #1;
        check("ign_in_ready", in_ready, 1);
        check("ign_addr", ram_address, 4);
        tick;
        in_valid = 0;
        check("ign_done", done, 1);
        tick;
        check("ign_busy", busy, 0);
        check("ign_mem3", mem[3], 8'h55);
        check("ign_mem4", mem[4], 8'h66);
        wr_before = wr_cnt;
        start_addr = 4'd7; length = 5'd0; load_start = 1;
        tick;
        load_start = 0; in_valid = 1; in_data = 8'h77;
        #1;
        check("z_done", done, 1);
        check("z_in_ready", in_ready, 0);
        check("z_we", ram_write_enable, 0);
        tick;
        in_valid = 0;
        check("z_busy", busy, 0);
        check("z_wr_cnt", wr_cnt, wr_before);
        check("z_mem7", mem[7], 8'h00);

        // Test 5: reset mid-load after 5 of 8 bytes
        start_addr = 4'd0; length = 5'd8; load_start = 1;
        tick;
        load_start = 0; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick;
        end
        in_data = 8'hA5; reset = 0;
        #1;
        check("mr_we_gated", ram_write_enable, 0);
        tick;
        reset = 1; in_valid = 0;
        check("mr_busy", busy, 0);
        check("mr_in_ready", in_ready, 0);
        check("mr_mem0", mem[0], 8'hA0);
        check("mr_mem4", mem[4], 8'hA4);
        check("mr_mem5", mem[5], 8'h00);

`ifdef LOADER_CHECKSUM_EN
        // Test 6: checksum over load and dump of 0x80,0x90,0x01
        start_addr = 4'd8; length = 5'd3; load_start = 1;
        tick;
        load_start = 0; in_valid = 1;
        check("ck_cleared_ld", checksum, 0);
        in_data = 8'h80; tick;
        in_data = 8'h90; tick;
        in_data = 8'h01; tick;
        in_valid = 0;
        check("ck_load", checksum, 8'h11);
        tick;
        start_addr = 4'd8; length = 5'd3; dump_start = 1;
        tick;
        dump_start = 0;
        check("ck_cleared_dp", checksum, 0);
        for (int i = 0; i < 3; i++) begin
            wait_out("ck_dp_timeout", n);
            tick;
        end
        check("ck_dump", checksum, 8'h11);
        tick;
        clear_start = 1;
        tick;
        clear_start = 0;
        tick; tick;
        check("ck_after_clear", checksum, 8'h11);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
